// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and types for the 1-to-4 word distributor
package demux_pkg;

  localparam int CH_NUM = 4;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

  typedef logic [1:0] ch_sel_t;

endpackage

// File: rtl/demux_chan_buf.sv
// rtl/demux_chan_buf.sv - one-entry channel slot with EMPTY/FULL state and data register
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = demux_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fill,
  input  logic [DATA_W-1:0] fill_data,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  ch_state_e         state_q;
  ch_state_e         state_d;
  logic [DATA_W-1:0] data_q;

  // State register; reset empties the slot immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CH_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a fill wins over a same-cycle drain so the slot stays full.
  always_comb begin
    state_d = state_q;
    if (fill) begin
      state_d = CH_FULL;
    end else if ((state_q == CH_FULL) && out_ready) begin
      state_d = CH_EMPTY;
    end
  end

  // Data register keeps the last word after a drain; only a fill replaces it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else if (fill) begin
      data_q <= fill_data;
    end
  end

  assign out_valid = (state_q == CH_FULL);
  assign out_data  = data_q;

endmodule

// File: rtl/demux1t4_32_buf.sv
// rtl/demux1t4_32_buf.sv - registered 1-to-4 word distributor, optional DEMUX_CNT_EN transfer counters
module demux1t4_32_buf
  import demux_pkg::*;
#(
  parameter int DATA_W = demux_pkg::DATA_W,
  parameter int CNT_W  = demux_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        s,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data0,
  output logic [DATA_W-1:0] out_data1,
  output logic [DATA_W-1:0] out_data2,
  output logic [DATA_W-1:0] out_data3,
  input  logic [3:0]        out_ready,
  output logic              busy,
  input  logic [1:0]        cnt_sel,
  output logic [CNT_W-1:0]  cnt_val
);

  logic [CH_NUM-1:0] full;
  logic [CH_NUM-1:0] fill;
  logic [DATA_W-1:0] slot_data [CH_NUM];
  logic              accept;

  // A selected channel can take a word when empty or when it is draining this cycle.
  assign in_ready = rst_n & (~full[s] | out_ready[s]);
  assign accept   = in_valid & in_ready;

  genvar gi;
  generate
    for (gi = 0; gi < CH_NUM; gi++) begin : g_chan
      assign fill[gi] = accept & (s == ch_sel_t'(gi));

      demux_chan_buf #(
        .DATA_W (DATA_W)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .fill      (fill[gi]),
        .fill_data (in_data),
        .out_ready (out_ready[gi]),
        .out_valid (full[gi]),
        .out_data  (slot_data[gi])
      );
    end
  endgenerate

  assign out_valid = full;
  assign busy      = |full;
  assign out_data0 = slot_data[0];
  assign out_data1 = slot_data[1];
  assign out_data2 = slot_data[2];
  assign out_data3 = slot_data[3];

`ifdef DEMUX_CNT_EN
  logic [CNT_W-1:0] cnt_q [CH_NUM];

  // Per-channel accept counters, free-running with natural wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CH_NUM; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CH_NUM; i++) begin
        if (fill[i]) begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign cnt_val = cnt_q[cnt_sel];
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_val        = '0;
`endif

endmodule

// File: tb/tb_demux1t4_32_buf.sv
// tb/tb_demux1t4_32_buf.sv - scoreboard bench for the 1-to-4 word distributor
module tb_demux1t4_32_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  s = 2'd0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready;
  logic [3:0]  out_valid;
  logic [31:0] out_data0, out_data1, out_data2, out_data3;
  logic [3:0]  out_ready = 4'b0000;
  logic        busy;
  logic [1:0]  cnt_sel = 2'd0;
  logic [15:0] cnt_val;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] exp_q [4][$];
  int          cnt_model [4];

  demux1t4_32_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s         (s),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data0 (out_data0),
    .out_data1 (out_data1),
    .out_data2 (out_data2),
    .out_data3 (out_data3),
    .out_ready (out_ready),
    .busy      (busy),
    .cnt_sel   (cnt_sel),
    .cnt_val   (cnt_val)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] data_of(input int ch);
    case (ch)
      0:       return out_data0;
      1:       return out_data1;
      2:       return out_data2;
      default: return out_data3;
    endcase
  endfunction

  function automatic int exp_cnt(input int ch);
`ifdef DEMUX_CNT_EN
    return cnt_model[ch];
`else
    return 0 * ch;
`endif
  endfunction

  // Reference model reset: every buffered word is lost, counts restart.
  always @(negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      cnt_model[i] = 0;
    end
  end

  // Monitor: each channel is a one-deep FIFO of accepted words in the model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_out_data", {out_data0 | out_data1, out_data2 | out_data3}, 64'd0);
      check("rst_cnt_val", 64'(cnt_val), 64'd0);
    end else begin
      automatic bit any = 1'b0;
      for (int i = 0; i < 4; i++) begin
        check($sformatf("out_valid%0d", i), 64'(out_valid[i]), 64'(exp_q[i].size() != 0));
        any |= (exp_q[i].size() != 0);
      end
      check("busy", 64'(busy), 64'(any));
      check("in_ready", 64'(in_ready), 64'((exp_q[s].size() == 0) || out_ready[s]));
      check("cnt_val", 64'(cnt_val), 64'(exp_cnt(cnt_sel)));
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i] && exp_q[i].size() != 0) begin
          check($sformatf("out_data%0d", i), 64'(data_of(i)), 64'(exp_q[i].pop_front()));
        end
      end
      if (in_valid && in_ready) begin
        exp_q[s].push_back(in_data);
        cnt_model[s] = (cnt_model[s] + 1) % 65536;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_in_ready_tb", 64'(in_ready), 64'd0);
    check("rst_valid_tb", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 64'(in_ready), 64'd1);
    tick();

    // Single word, no drain
    s = 2'd2; in_data = 32'hDEADBEEF; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("single_valid", 64'(out_valid), 64'h4);
      check("single_data2", 64'(out_data2), 64'hDEADBEEF);
      check("single_busy", 64'(busy), 64'd1);
      tick();
    end
    out_ready = 4'b0100;
    tick();
    out_ready = 4'b0000;
    check("single_drained", 64'(out_valid), 64'd0);

    // Backpressure on ch1, then route around it to ch3
    s = 2'd1; in_data = 32'h11; in_valid = 1'b1;
    tick();
    in_data = 32'h22;
    #1;
    check("bp_in_ready", 64'(in_ready), 64'd0);
    tick();
    check("bp_data1_hold", 64'(out_data1), 64'h11);
    s = 2'd3; in_data = 32'h33;
    #1;
    check("bp_alt_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    check("bp_valid", 64'(out_valid), 64'hA);
    check("bp_data3", 64'(out_data3), 64'h33);
    out_ready = 4'b1010;
    tick();
    out_ready = 4'b0000;

    // Streaming through ch0 at one word per cycle
    s = 2'd0; out_ready = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      in_data = 32'(k); in_valid = 1'b1;
      #1;
      check("stream_ready", 64'(in_ready), 64'd1);
      tick();
      check("stream_data0", 64'(out_data0), 64'(k));
      check("stream_valid0", 64'(out_valid[0]), 64'd1);
    end
    in_valid = 1'b0;
    tick();
    check("stream_end", 64'(out_valid), 64'd0);
    out_ready = 4'b0000;

    // Async reset pulse between edges discards ch0 and ch3
    s = 2'd0; in_data = 32'hA0; in_valid = 1'b1; tick();
    s = 2'd3; in_data = 32'hA3; tick();
    in_valid = 1'b0;
    check("pre_rst_valid", 64'(out_valid), 64'h9);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 64'(out_valid), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    #1;
    rst_n = 1'b1;
    out_ready = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_rst_empty", 64'(out_valid), 64'd0);
    end
    out_ready = 4'b0000;

    // Counters
    for (int k = 0; k < 7; k++) begin
      s = (k < 5) ? 2'd1 : 2'd3;
      in_data = $urandom; in_valid = 1'b1; out_ready = 4'b1111;
      tick();
    end
    in_valid = 1'b0;
    tick();
    cnt_sel = 2'd1; #1;
`ifdef DEMUX_CNT_EN
    check("cnt1", 64'(cnt_val), 64'd5);
    cnt_sel = 2'd3; #1;
    check("cnt3", 64'(cnt_val), 64'd2);
    cnt_sel = 2'd0; #1;
    check("cnt0", 64'(cnt_val), 64'd0);
    s = 2'd1; out_ready = 4'b0010; in_valid = 1'b1;
    for (int k = 0; k < 65536; k++) begin
      in_data = 32'(k);
      tick();
    end
    in_valid = 1'b0;
    tick();
    cnt_sel = 2'd1; #1;
    check("cnt1_wrap", 64'(cnt_val), 64'd5);
`else
    check("cnt_off1", 64'(cnt_val), 64'd0);
    cnt_sel = 2'd3; #1;
    check("cnt_off3", 64'(cnt_val), 64'd0);
`endif
    out_ready = 4'b0000;
    tick();

    // Randomized traffic with legal producer holding behaviour
    for (int k = 0; k < 2000; k++) begin
      automatic bit acc;
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        s        = 2'($urandom_range(0, 3));
        in_data  = $urandom;
      end
      out_ready = 4'($urandom);
      cnt_sel   = 2'($urandom_range(0, 3));
    end

    // Final drain: every accepted word must have come out
    @(negedge clk);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 4'b1111;
    repeat (4) tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("leftover%0d", i), 64'(exp_q[i].size()), 64'd0);
    end
    check("final_idle", 64'(out_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
